// File: rtl/rv32i_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_ctrl_pkg
// Shared definitions for the multicycle RV32I control unit.
//   - state_t        : control FSM states
//   - OP_*           : major opcodes that the decoder recognises
//   - ALU_*          : ALUControl encodings driven to the datapath ALU
//   - ALUOP_*        : coarse ALU request from the FSM to alu_decoder
//   - F3_*           : funct3 values for the branch comparisons
//   - imm_src_for()  : immediate format selection from the opcode
// ----------------------------------------------------------------------------
package rv32i_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_DECODE = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // Immediate format: 00 I-type/load, 01 store, 10 branch, 11 jal.
    // Opcodes without an immediate fall back to the I-type format.
    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:  return 2'b01;
            OP_BRANCH: return 2'b10;
            OP_JAL:    return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Combinational translation of the FSM's coarse ALU request into the 3-bit
// ALUControl code.
// Ports:
//   alu_op      in  2 : 00 add, 01 sub, 10 decode from funct3/funct7
//   funct3      in  3 : instruction funct3 field
//   funct7b5    in  1 : bit 5 of funct7 (selects sub for R-type)
//   op5         in  1 : bit 5 of the opcode (1 for R-type, 0 for I-type)
//   alu_control out 3 : ALU operation select
// ----------------------------------------------------------------------------
module alu_decoder
    import rv32i_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // funct7b5 only means "subtract" for register-register ops; addi reuses
    // the same bit position for immediate data, hence the op5 qualifier.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_DECODE: begin
                case (funct3)
                    3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Moore-style control FSM for a multicycle RV32I datapath.
// Optional feature: define BRANCH_EXT_EN to add bne/blt/bge; without it only
// beq can be taken.
// Ports:
//   clk, rst               : clock (rising edge), async active-high reset
//   op, funct3, funct7b5   : instruction fields from the instruction register
//   Zero, Negative,
//   OverFlow               : ALU flags, valid in the cycle ALUControl is shown
//   mem_ready              : memory access completes this cycle
//   PCWrite, AdrSrc,
//   MemWrite, IRWrite,
//   RegWrite               : datapath enables / selects
//   ResultSrc, ALUSrcA,
//   ALUSrcB, ImmSrc        : 2-bit datapath mux selects
//   ALUControl             : ALU operation
//   illegal_instr          : one-cycle pulse on an unrecognised opcode
// ----------------------------------------------------------------------------
module multicycle_control
    import rv32i_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Negative,
    input  logic       OverFlow,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_instr
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;
    logic       taken;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Branch resolution from the flags of the subtract done in BRANCH.
`ifdef BRANCH_EXT_EN
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = Zero;
            F3_BNE:  taken = ~Zero;
            F3_BLT:  taken = Negative ^ OverFlow;
            F3_BGE:  taken = ~(Negative ^ OverFlow);
            default: taken = 1'b0;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = Negative ^ OverFlow;

    always_comb begin
        taken = (funct3 == F3_BEQ) ? Zero : 1'b0;
    end
`endif

    assign ImmSrc = imm_src_for(op);

    // Next state and per-state outputs. All enables are forced low while
    // rst is high: FETCH would otherwise raise IRWrite/PCWrite on mem_ready
    // during reset.
    always_comb begin
        next_state    = FETCH;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;

        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECUTER;
                    OP_ITYPE:          next_state = EXECUTEI;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    default: begin
                        illegal_instr = 1'b1;
                        next_state    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                next_state = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                alu_op     = ALUOP_DECODE;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = ALUOP_DECODE;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                alu_op     = ALUOP_SUB;
                PCWrite    = taken;
                next_state = FETCH;
            end
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCWrite    = 1'b1;
                next_state = ALUWB;
            end
            default: next_state = FETCH;
        endcase

        if (rst) begin
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            MemWrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Directed, table-driven bench for multicycle_control. Each table row is one
// clock cycle: inputs are driven on the falling edge and the full output
// bundle is compared 1 ns later against a hand-written expectation. A
// hand-written sequence afterwards covers reset arriving mid-store.
// Define BRANCH_EXT_EN for both bench and RTL to exercise the extended
// branch set.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       Negative;
    logic       OverFlow;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal_instr;

    int vectors;
    int miscompares;

`ifdef BRANCH_EXT_EN
    localparam logic EXT = 1'b1;
`else
    localparam logic EXT = 1'b0;
`endif

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] B   = 7'b1100011;
    localparam logic [6:0] J   = 7'b1101111;
    localparam logic [6:0] ILL = 7'b0000000;

    typedef struct {
        string       name;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        n;
        logic        v;
        logic        rdy;
        logic [16:0] expected;
    } vec_t;

    vec_t vecs[$];

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .Zero          (Zero),
        .Negative      (Negative),
        .OverFlow      (OverFlow),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .AdrSrc        (AdrSrc),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ImmSrc        (ImmSrc),
        .ALUControl    (ALUControl),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle order: PCWrite AdrSrc MemWrite IRWrite RegWrite
    // ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl illegal_instr.
    function automatic logic [16:0] outs(input logic pcw, input logic adr,
                                         input logic mw, input logic irw,
                                         input logic rw, input logic [1:0] rs,
                                         input logic [1:0] sa, input logic [1:0] sb,
                                         input logic [1:0] imm, input logic [2:0] alu,
                                         input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    function automatic void addVec(input string name, input logic r, input logic [6:0] o,
                                   input logic [2:0] f3, input logic f7, input logic z,
                                   input logic n, input logic v, input logic rdy,
                                   input logic [16:0] e);
        vec_t t;
        t.name = name; t.rst = r; t.op = o; t.f3 = f3; t.f7 = f7;
        t.z = z; t.n = n; t.v = v; t.rdy = rdy; t.expected = e;
        vecs.push_back(t);
    endfunction

    // Drive one cycle's inputs.
    task automatic applyStimulus(input logic r, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic n,
                                 input logic v, input logic rdy);
        rst = r; op = o; funct3 = f3; funct7b5 = f7;
        Zero = z; Negative = n; OverFlow = v; mem_ready = rdy;
    endtask

    // Compare the whole output bundle against its expectation.
    task automatic checkOutput(input string name, input logic [16:0] expected);
        logic [16:0] actual;
        actual = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        applyStimulus(1'b1, R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset: FETCH selects shown, but enables gated even with mem_ready=1.
        addVec("rst_fetch",     1, R, 3'b000, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));

        // add: FETCH, DECODE, EXECUTER, ALUWB
        addVec("add_fetch",     0, R, 3'b000, 0, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        addVec("add_decode",    0, R, 3'b000, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        addVec("add_exec",      0, R, 3'b000, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0));
        addVec("add_wb",        0, R, 3'b000, 0, 0, 0, 0, 1, outs(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        // sub, with one FETCH wait cycle first
        addVec("sub_fetch_wait",0, R, 3'b000, 1, 0, 0, 0, 0, outs(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        addVec("sub_fetch",     0, R, 3'b000, 1, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        addVec("sub_decode",    0, R, 3'b000, 1, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        addVec("sub_exec",      0, R, 3'b000, 1, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0));
        addVec("sub_wb",        0, R, 3'b000, 1, 0, 0, 0, 1, outs(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        // slt and or (R-type)
        addVec("slt_fetch",     0, R, 3'b010, 0, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        addVec("slt_decode",    0, R, 3'b010, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        addVec("slt_exec",      0, R, 3'b010, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b101,0));
        addVec("slt_wb",        0, R, 3'b010, 0, 0, 0, 0, 1, outs(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        addVec("or_fetch",      0, R, 3'b110, 0, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        addVec("or_decode",     0, R, 3'b110, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        addVec("or_exec",       0, R, 3'b110, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b011,0));
        addVec("or_wb",         0, R, 3'b110, 0, 0, 0, 0, 1, outs(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        // addi with funct7b5=1 must still add (op[5]=0); andi; funct3 100 -> add
        addVec("addi_fetch",    0, I, 3'b000, 1, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        addVec("addi_decode",   0, I, 3'b000, 1, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        addVec("addi_exec",     0, I, 3'b000, 1, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        addVec("addi_wb",       0, I, 3'b000, 1, 0, 0, 0, 1, outs(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        addVec("andi_fetch",    0, I, 3'b111, 0, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        addVec("andi_decode",   0, I, 3'b111, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        addVec("andi_exec",     0, I, 3'b111, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b010,0));
        addVec("andi_wb",       0, I, 3'b111, 0, 0, 0, 0, 1, outs(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        addVec("xori_fetch",    0, I, 3'b100, 0, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        addVec("xori_decode",   0, I, 3'b100, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        addVec("xori_exec",     0, I, 3'b100, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        addVec("xori_wb",       0, I, 3'b100, 0, 0, 0, 0, 1, outs(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        // lw with three wait cycles in MEMREAD
        addVec("lw_fetch",      0, LW, 3'b010, 0, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        addVec("lw_decode",     0, LW, 3'b010, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        addVec("lw_memadr",     0, LW, 3'b010, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        addVec("lw_read_wait1", 0, LW, 3'b010, 0, 0, 0, 0, 0, outs(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        addVec("lw_read_wait2", 0, LW, 3'b010, 0, 0, 0, 0, 0, outs(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        addVec("lw_read_wait3", 0, LW, 3'b010, 0, 0, 0, 0, 0, outs(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        addVec("lw_read_done",  0, LW, 3'b010, 0, 0, 0, 0, 1, outs(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        addVec("lw_memwb",      0, LW, 3'b010, 0, 0, 0, 0, 1, outs(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));

        // sw with one wait cycle in MEMWRITE
        addVec("sw_fetch",      0, SW, 3'b010, 0, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        addVec("sw_decode",     0, SW, 3'b010, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
        addVec("sw_memadr",     0, SW, 3'b010, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
        addVec("sw_write_wait", 0, SW, 3'b010, 0, 0, 0, 0, 0, outs(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        addVec("sw_write_done", 0, SW, 3'b010, 0, 0, 0, 0, 1, outs(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));

        // beq taken, beq not taken
        addVec("beq1_fetch",    0, B, 3'b000, 0, 1, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        addVec("beq1_decode",   0, B, 3'b000, 0, 1, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        addVec("beq1_branch",   0, B, 3'b000, 0, 1, 0, 0, 1, outs(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
        addVec("beq0_fetch",    0, B, 3'b000, 0, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        addVec("beq0_decode",   0, B, 3'b000, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        addVec("beq0_branch",   0, B, 3'b000, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));

        // Extended branches: taken only when the feature is built in.
        addVec("bne_fetch",     0, B, 3'b001, 0, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        addVec("bne_decode",    0, B, 3'b001, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        addVec("bne_branch",    0, B, 3'b001, 0, 0, 0, 0, 1, outs(EXT,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
        addVec("blt10_fetch",   0, B, 3'b100, 0, 0, 1, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        addVec("blt10_decode",  0, B, 3'b100, 0, 0, 1, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        addVec("blt10_branch",  0, B, 3'b100, 0, 0, 1, 0, 1, outs(EXT,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
        addVec("blt11_fetch",   0, B, 3'b100, 0, 0, 1, 1, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        addVec("blt11_decode",  0, B, 3'b100, 0, 0, 1, 1, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        addVec("blt11_branch",  0, B, 3'b100, 0, 0, 1, 1, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
        addVec("bge11_fetch",   0, B, 3'b101, 0, 0, 1, 1, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        addVec("bge11_decode",  0, B, 3'b101, 0, 0, 1, 1, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        addVec("bge11_branch",  0, B, 3'b101, 0, 0, 1, 1, 1, outs(EXT,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
        addVec("bgeu_fetch",    0, B, 3'b111, 0, 1, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        addVec("bgeu_decode",   0, B, 3'b111, 0, 1, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        addVec("bgeu_branch",   0, B, 3'b111, 0, 1, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));

        // jal: JAL then ALUWB
        addVec("jal_fetch",     0, J, 3'b000, 0, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b11,3'b000,0));
        addVec("jal_decode",    0, J, 3'b000, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0));
        addVec("jal_jal",       0, J, 3'b000, 0, 0, 0, 0, 1, outs(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0));
        addVec("jal_wb",        0, J, 3'b000, 0, 0, 0, 0, 1, outs(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,0));

        // Illegal opcode: one-cycle pulse in DECODE, straight back to FETCH.
        addVec("ill_fetch",     0, ILL, 3'b000, 0, 0, 0, 0, 1, outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        addVec("ill_decode",    0, ILL, 3'b000, 0, 0, 0, 0, 1, outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,1));
        addVec("ill_refetch",   0, ILL, 3'b000, 0, 0, 0, 0, 0, outs(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7,
                          vecs[i].z, vecs[i].n, vecs[i].v, vecs[i].rdy);
            #1;
            checkOutput(vecs[i].name, vecs[i].expected);
        end

        // Reset arriving mid-MEMWRITE: MemWrite must drop without waiting for
        // a clock edge, and nothing is fetched until reset releases.
        @(negedge clk);
        applyStimulus(0, SW, 3'b010, 0, 0, 0, 0, 1);
        #1 checkOutput("rsw_fetch", outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        @(negedge clk);
        #1 checkOutput("rsw_decode", outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
        @(negedge clk);
        #1 checkOutput("rsw_memadr", outs(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
        @(negedge clk);
        mem_ready = 1'b0;
        #1 checkOutput("rsw_write", outs(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        #1;
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1 checkOutput("rsw_abort", outs(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        @(negedge clk);
        #1 checkOutput("rsw_hold", outs(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        #1 checkOutput("rsw_post_wait", outs(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        @(negedge clk);
        mem_ready = 1'b1;
        #1 checkOutput("rsw_post_fetch", outs(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        @(negedge clk);
        #1 checkOutput("rsw_post_decode", outs(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock, rising edge); rst in 1 (async, active-high).
REQ-002 SHALL have: op in 7; funct3 in 3; funct7b5 in 1 (instruction fields).
REQ-003 SHALL have: Zero, Negative, OverFlow in 1 each (ALU flags, same cycle as ALUControl).
REQ-004 SHALL have: mem_ready in 1 (memory access completes this cycle).
REQ-005 SHALL have outputs: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite 1 each; ResultSrc 2; ALUSrcA 2; ALUSrcB 2; ImmSrc 2; ALUControl 3; illegal_instr 1.

Function
REQ-006 SHALL implement Moore FSM states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
REQ-007 ALUControl encoding SHALL be 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-008 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=1 only when mem_ready; hold FETCH while mem_ready=0, else -> DECODE.
REQ-009 DECODE: ALUSrcA=01, ALUSrcB=01, add; op 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BRANCH, 1101111 -> JAL.
REQ-010 DECODE with any other op SHALL pulse illegal_instr for one cycle and -> FETCH, no write enable asserted.
REQ-011 MEMADR: ALUSrcA=10, ALUSrcB=01, add; op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
REQ-012 MEMREAD: AdrSrc=1, ResultSrc=00; hold until mem_ready, then -> MEMWB.
REQ-013 MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
REQ-014 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle in state; -> FETCH when mem_ready.
REQ-015 EXECUTER: ALUSrcA=10, ALUSrcB=00; EXECUTEI: ALUSrcA=10, ALUSrcB=01; both ALU-decoded op -> ALUWB.
REQ-016 ALU decode: funct3 000 -> sub if funct7b5&op[5] else add; 010 -> slt; 110 -> or; 111 -> and; other funct3 -> add.
REQ-017 ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-018 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite=taken, same cycle; -> FETCH.
REQ-019 funct3 000 (beq): taken=Zero; other funct3 without REQ-026 feature: not taken.
REQ-020 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB.
REQ-021 ImmSrc SHALL be combinational from op: I/load 00, store 01, branch 10, jal 11, other 00.
REQ-022 Unlisted outputs SHALL be 0 in every state; write enables never X.

Reset
REQ-023 rst high SHALL force state=FETCH asynchronously.
REQ-024 While rst high, PCWrite, IRWrite, RegWrite, MemWrite, illegal_instr SHALL be 0 regardless of mem_ready.
REQ-025 rst mid-MEMWRITE/MEMREAD SHALL abort access; MemWrite drops same cycle; first post-reset edge evaluates FETCH.

Configuration
REQ-026 Macro BRANCH_EXT_EN defined: funct3 001 bne taken=~Zero; 100 blt taken=Negative^OverFlow; 101 bge taken=~(Negative^OverFlow); 110/111 not taken.
REQ-027 Macro undefined: only beq taken per REQ-019; Negative/OverFlow unused.

Structure
REQ-028 Package rv32i_ctrl_pkg SHALL hold state enum, opcode constants, ALUControl constants, ALUOp codes.
REQ-029 Combinational sub-module alu_decoder (ALUOp, funct3, funct7b5, op5 -> ALUControl) SHALL implement REQ-016; FSM supplies ALUOp 00 add, 01 sub, 10 decode.

Verification
REQ-030 add (op 0110011, funct3 000, funct7b5 0), mem_ready=1 -> FETCH,DECODE,EXECUTER(ALUControl 000),ALUWB(RegWrite 1): 4 cycles.
REQ-031 lw with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, RegWrite only in MEMWB, ResultSrc 01.
REQ-032 beq Zero=1 -> PCWrite 1 in BRANCH; Zero=0 -> PCWrite 0; ALUControl 001 both.
REQ-033 BRANCH_EXT_EN, blt, Negative=1 OverFlow=0 -> taken; Negative=1 OverFlow=1 -> not taken; macro off -> not taken.
REQ-034 op 0000000 -> illegal_instr one cycle in DECODE, no enables, next FETCH.
REQ-035 rst asserted mid-MEMWRITE (MemWrite 1) -> MemWrite 0 immediately, state FETCH, no IRWrite until rst low and mem_ready 1.
